// File: rtl/countdown_timer_core_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_core_if
// Signal bundle between the digit-setting stage, the countdown core and the
// display/alarm logic.
//   set_value : BCD minutes from the setter ([7:4] tens, [3:0] ones)
//   start     : single-cycle pulse, load and run / resume
//   pause     : single-cycle pulse, toggle RUN/PAUSE
//   clear     : single-cycle pulse, abort to IDLE
//   min_bcd   : current minutes, BCD
//   sec_bcd   : current seconds, BCD
//   running   : high while counting
//   expired   : high once the count has reached 00:00
//   done      : one-cycle pulse on reaching 00:00
// master drives the controls and observes the time; slave is the core.
// -----------------------------------------------------------------------------
interface countdown_timer_core_if;
  logic [7:0] set_value;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output set_value, start, pause, clear,
    input  min_bcd, sec_bcd, running, expired, done
  );

  modport slave (
    input  set_value, start, pause, clear,
    output min_bcd, sec_bcd, running, expired, done
  );
endinterface

// File: rtl/countdown_timer_core.sv
// -----------------------------------------------------------------------------
// countdown_timer_core
// Runs a two-digit BCD minute setting down to 00:00 in MM:SS form, one second
// per TICK_DIV clock cycles.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   tmr   : countdown_timer_core_if.slave (set_value/start/pause/clear in,
//           min_bcd/sec_bcd/running/expired/done out)
// Parameters:
//   TICK_DIV : clk cycles per one-second tick (>= 2)
//   CNT_W    : prescaler width, 2**CNT_W >= TICK_DIV
// -----------------------------------------------------------------------------
module countdown_timer_core #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input logic                    clk,
  input logic                    reset,
  countdown_timer_core_if.slave  tmr
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] presc;
  logic [7:0]       min_q;
  logic [7:0]       sec_q;
  logic             running_q;
  logic             expired_q;
  logic             done_q;

  logic [7:0]       set_clamped;
  logic             set_nonzero;
  logic [15:0]      time_dec;
  logic             tick;
  logic             last_sec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

  // One-second BCD decrement of MM:SS; seconds wrap 00 -> 59 with a borrow
  // from minutes. Never called at 00:00 because the core leaves RUN at 00:01.
  function automatic logic [15:0] dec_time(input logic [7:0] m,
                                           input logic [7:0] s);
    logic [7:0] m_n;
    logic [7:0] s_n;
    m_n = m;
    s_n = s;
    if (s[3:0] != 4'd0) begin
      s_n[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      s_n[7:4] = s[7:4] - 4'd1;
      s_n[3:0] = 4'd9;
    end else begin
      s_n = 8'h59;
      if (m[3:0] != 4'd0) begin
        m_n[3:0] = m[3:0] - 4'd1;
      end else begin
        m_n[3:0] = 4'd9;
        m_n[7:4] = m[7:4] - 4'd1;
      end
    end
    return {m_n, s_n};
  endfunction

  always_comb begin
    set_clamped = clamp_bcd(tmr.set_value);
    set_nonzero = (set_clamped != 8'h00);
    time_dec    = dec_time(min_q, sec_q);
    tick        = (presc == PRESC_LAST);
    last_sec    = (min_q == 8'h00) && (sec_q == 8'h01);
  end

  // Priority each cycle: clear > start > pause > tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmr.clear) begin
        // Time digits are left alone here; IDLE reloads them next cycle.
        state     <= IDLE;
        presc     <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            min_q <= set_clamped;
            sec_q <= 8'h00;
            if (tmr.start && set_nonzero) begin
              state     <= RUN;
              presc     <= '0;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (tmr.pause) begin
              // A tick landing on this cycle is dropped; prescaler holds.
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              presc          <= '0;
              {min_q, sec_q} <= time_dec;
              if (last_sec) begin
                state     <= DONE;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end else begin
              presc <= presc + CNT_W'(1);
            end
          end
          PAUSE: begin
            if (tmr.start || tmr.pause) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
            if (tmr.start && set_nonzero) begin
              state     <= RUN;
              presc     <= '0;
              min_q     <= set_clamped;
              sec_q     <= 8'h00;
              running_q <= 1'b1;
              expired_q <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tmr.min_bcd = min_q;
  assign tmr.sec_bcd = sec_q;
  assign tmr.running = running_q;
  assign tmr.expired = expired_q;
  assign tmr.done    = done_q;

endmodule

// File: doc/countdown_timer_core.md
Name: countdown_timer_core

Overview:
Consumes the 8-bit two-digit BCD set value (bits [3:0] ones-minutes, [7:4] tens-minutes) produced by the add/sub digit-setting stage, and runs it down to 00:00 in MM:SS form. Sits directly downstream of the setter and upstream of the display/alarm logic. It drives the expired indication that the setting stage and display use to return to idle.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (legal range ≥2; bench uses 4)
CNT_W, 26, prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
set_value  input  8  BCD minutes from setter ([7:4] tens, [3:0] ones)
start  input  1  single-cycle pulse: load and run / resume
pause  input  1  single-cycle pulse: toggle RUN/PAUSE
clear  input  1  single-cycle pulse: abort to IDLE
min_bcd  output  8  current minutes, BCD
sec_bcd  output  8  current seconds, BCD (tens digit 0-5)
running  output  1  high in RUN
expired  output  1  high in DONE
done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All state is registered.
- Reset: state=IDLE; prescaler=0; min_bcd=8'h00; sec_bcd=8'h00; running=0; expired=0; done=0.
- Digit clamp: any set_value nibble >9 is treated as 9 wherever set_value is used.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority each cycle: clear > start > pause > tick.
- IDLE:
  - Each cycle, min_bcd <= clamped set_value and sec_bcd <= 00. Display follows the setter with 1-cycle latency.
  - start with clamped set_value ≠ 00: load min_bcd=clamped set_value, sec_bcd=00, prescaler=0, go to RUN.
  - start with set_value = 00: ignored; stay in IDLE with no done.
  - pause is ignored.
- RUN:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and asserts an internal tick.
  - On tick:
    - sec ones ≠ 0: decrement it.
    - else sec tens ≠ 0: sec tens-1, sec ones=9.
    - else (sec = 00): borrow from minutes. sec=59; min ones-1, or if min ones = 0, min ones=9 and min tens-1.
  - A tick at 00:01 produces 00:00 and moves to DONE in the same edge; done=1 for exactly the next cycle.
  - pause: go to PAUSE. That cycle the prescaler and time are not advanced, and a coincident tick is discarded (prescaler holds at TICK_DIV-1).
  - start in RUN is ignored.
- PAUSE:
  - Time and prescaler are held.
  - pause or start: return to RUN; the prescaler resumes from its held value.
- DONE:
  - Holds 00:00; expired=1.
  - start: reloads from set_value exactly as in IDLE (the zero-set rule applies; a zero set stays in DONE).
  - pause is ignored.
- clear, from any state: go to IDLE with prescaler=0 and done=0. min_bcd is reloaded from set_value on the next IDLE cycle.
- Reset asserted mid-count: immediate return to reset values regardless of clk.
- Maximum load 99:00; the count never underflows below 00:00.
- running = (state==RUN); expired = (state==DONE). Both are registered state decodes.

Test Plan:
- Reset/idle follow (TICK_DIV=4): assert reset with set_value=8'h25 -> all outputs 0. Release reset -> min_bcd=8'h25, sec_bcd=8'h00 one cycle later, running=0.
- Basic countdown: set 8'h01, start -> running=1. The first tick after 4 cycles gives 00:59, then 00:58… After 60 ticks (240 cycles), 00:00, expired=1, and a single-cycle done pulse.
- Minute/BCD borrow: set 8'h10, start -> the first tick gives min_bcd=8'h09, sec_bcd=8'h59. Never 8'h0F or 8'h5F.
- Pause on tick cycle: pause asserted while the prescaler is at 3 -> time unchanged, state PAUSE. Hold 20 cycles, no change. Pause again -> the next tick occurs on the following cycle.
- Clamp and zero start: set 8'hAF, start -> loads 8'h99. Set 8'h00, start -> stays IDLE, done never asserts.
- Clear and async reset mid-run: clear at 00:37 -> IDLE, min_bcd=set_value next cycle. Assert reset between clk edges mid-run -> outputs zero immediately.
